bandit_arbiter: RTL and testbench

Shares one bandit agent's action/reward stream pair among `CLIENTS` environment requesters, so several environments can be served by a single agent.

- Grants one client at a time, round-robin.
- Forwards the agent's action to the granted client, then forwards that client's reward back to the agent.
- If the client never answers, injects a penalty reward so the agent's state machine never stalls.
- Sits between the bandit agent and the environment front-ends.

---
 rtl/bandit_arbiter.sv | 162 ++++++++++++++++
 tb/tb_bandit_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/bandit_arbiter.sv
// Round-robin arbiter that shares one bandit agent's action/reward streams among
// several environment clients, injecting a penalty reward when a client stalls.
module bandit_arbiter #(
  parameter int         CLIENTS = 4,
  parameter int         TIMEOUT = 1000,
  parameter logic [7:0] PENALTY = 8'h80
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [CLIENTS-1:0]     request,
  output logic [CLIENTS-1:0]     grant,
  input  logic                   agent_action_valid,
  input  logic [7:0]             agent_action_data,
  output logic                   agent_action_ready,
  output logic                   agent_reward_valid,
  output logic [7:0]             agent_reward_data,
  input  logic                   agent_reward_ready,
  output logic [CLIENTS-1:0]     client_action_valid,
  output logic [7:0]             client_action_data,
  input  logic [CLIENTS-1:0]     client_action_ready,
  input  logic [CLIENTS-1:0]     client_reward_valid,
  input  logic [8*CLIENTS-1:0]   client_reward_data,
  output logic [CLIENTS-1:0]     client_reward_ready,
  output logic [7:0]             timeout_count
);

  localparam int PW = (CLIENTS > 1) ? $clog2(CLIENTS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACTION   = 2'd1,
    ST_REWARD   = 2'd2,
    ST_PENALIZE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CLIENTS-1:0]  grant_q, grant_d;
  logic [PW-1:0]       gidx_q, gidx_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [15:0]         timer_q, timer_d;
  logic [7:0]          tcount_q, tcount_d;

  logic [PW-1:0]       win_s;
  logic [PW-1:0]       nxt_ptr_s;
  logic                found_s;
  logic                rvld_s;

  assign grant         = grant_q;
  assign timeout_count = tcount_q;

  // Round-robin search: scanning downward in priority order lets the
  // lowest offset from ptr overwrite any earlier candidate.
  always_comb begin
    int            sum;
    logic [PW-1:0] cand;
    win_s   = '0;
    found_s = 1'b0;
    sum     = 0;
    cand    = '0;
    for (int k = CLIENTS - 1; k >= 0; k--) begin
      sum     = int'(ptr_q) + k;
      cand    = (sum >= CLIENTS) ? PW'(sum - CLIENTS) : PW'(sum);
      win_s   = request[cand] ? cand : win_s;
      found_s = found_s | request[cand];
    end
    nxt_ptr_s = (win_s == PW'(CLIENTS - 1)) ? '0 : win_s + 1'b1;
  end

  // Next-state logic and combinational stream steering for the granted client.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    gidx_d   = gidx_q;
    ptr_d    = ptr_q;
    timer_d  = timer_q;
    tcount_d = tcount_q;

    agent_action_ready  = 1'b0;
    agent_reward_valid  = 1'b0;
    agent_reward_data   = 8'h00;
    client_action_valid = '0;
    client_action_data  = 8'h00;
    client_reward_ready = '0;

    rvld_s = client_reward_valid[gidx_q];

    case (state_q)
      ST_IDLE: begin
        if (found_s) begin
          state_d = ST_ACTION;
          grant_d = {{(CLIENTS-1){1'b0}}, 1'b1} << win_s;
          gidx_d  = win_s;
          ptr_d   = nxt_ptr_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACTION: begin
        client_action_valid[gidx_q] = agent_action_valid;
        agent_action_ready          = client_action_ready[gidx_q];
        client_action_data          = agent_action_data;
        if (agent_action_valid && client_action_ready[gidx_q]) begin
          state_d = ST_REWARD;
          timer_d = 16'd0;
        end else begin
          state_d = ST_ACTION;
        end
      end
      ST_REWARD: begin
        agent_reward_valid          = rvld_s;
        agent_reward_data           = client_reward_data[{gidx_q, 3'b000} +: 8];
        client_reward_ready[gidx_q] = agent_reward_ready;
        // A reward arriving on the expiry cycle takes priority over the penalty.
        if (rvld_s && agent_reward_ready) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end else if (!rvld_s && (timer_q == 16'(TIMEOUT - 1))) begin
          state_d = ST_PENALIZE;
        end else if (!rvld_s) begin
          timer_d = timer_q + 16'd1;
        end else begin
          timer_d = timer_q;
        end
      end
      ST_PENALIZE: begin
        agent_reward_valid = 1'b1;
        agent_reward_data  = PENALTY;
        if (agent_reward_ready) begin
          state_d  = ST_IDLE;
          grant_d  = '0;
          tcount_d = (tcount_q == 8'hFF) ? tcount_q : tcount_q + 8'd1;
        end else begin
          state_d = ST_PENALIZE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State, grant, pointer, timer and penalty counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      gidx_q   <= '0;
      ptr_q    <= '0;
      timer_q  <= 16'd0;
      tcount_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gidx_q   <= gidx_d;
      ptr_q    <= ptr_d;
      timer_q  <= timer_d;
      tcount_q <= tcount_d;
    end
  end

endmodule

// File: tb/tb_bandit_arbiter.sv
// Directed bench for bandit_arbiter with CLIENTS=4, TIMEOUT=8: round-robin,
// pass-through, timeout/saturation, back-pressure, expiry collision and reset.
module tb_bandit_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  request;
  logic [3:0]  grant;
  logic        agent_action_valid;
  logic [7:0]  agent_action_data;
  logic        agent_action_ready;
  logic        agent_reward_valid;
  logic [7:0]  agent_reward_data;
  logic        agent_reward_ready;
  logic [3:0]  client_action_valid;
  logic [7:0]  client_action_data;
  logic [3:0]  client_action_ready;
  logic [3:0]  client_reward_valid;
  logic [31:0] client_reward_data;
  logic [3:0]  client_reward_ready;
  logic [7:0]  timeout_count;

  int checks   = 0;
  int failures = 0;

  bandit_arbiter #(.CLIENTS(4), .TIMEOUT(8), .PENALTY(8'h80)) dut (
    .clock               (clock),
    .reset               (reset),
    .request             (request),
    .grant               (grant),
    .agent_action_valid  (agent_action_valid),
    .agent_action_data   (agent_action_data),
    .agent_action_ready  (agent_action_ready),
    .agent_reward_valid  (agent_reward_valid),
    .agent_reward_data   (agent_reward_data),
    .agent_reward_ready  (agent_reward_ready),
    .client_action_valid (client_action_valid),
    .client_action_data  (client_action_data),
    .client_action_ready (client_action_ready),
    .client_reward_valid (client_reward_valid),
    .client_reward_data  (client_reward_data),
    .client_reward_ready (client_reward_ready),
    .timeout_count       (timeout_count)
  );

  always #5 clock = ~clock;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [3:0] rr_exp [5];

  initial begin
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;

    reset = 1'b1;
    request = 4'h0; agent_action_valid = 1'b0; agent_action_data = 8'h00;
    agent_reward_ready = 1'b0; client_action_ready = 4'h0;
    client_reward_valid = 4'h0; client_reward_data = 32'h0;
    repeat (3) tick();
    check_value("rst_grant", grant, 4'h0);
    check_value("rst_tcount", timeout_count, 8'h00);
    check_value("rst_arvalid", agent_reward_valid, 1'b0);
    check_value("rst_ardata", agent_reward_data, 8'h00);
    check_value("rst_cadata", client_action_data, 8'h00);
    reset = 1'b0;

    // Round-robin with every transfer immediate
    request = 4'hF; agent_action_valid = 1'b1; agent_action_data = 8'h01;
    client_action_ready = 4'hF; client_reward_valid = 4'hF; agent_reward_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_value($sformatf("rr_grant%0d", i), grant, rr_exp[i]);
      check_value($sformatf("rr_cavalid%0d", i), client_action_valid, rr_exp[i]);
      tick();
      check_value($sformatf("rr_arvalid%0d", i), agent_reward_valid, 1'b1);
      check_value($sformatf("rr_crready%0d", i), client_reward_ready, rr_exp[i]);
      tick();
      check_value($sformatf("rr_idle%0d", i), grant, 4'h0);
    end
    request = 4'h0; agent_action_valid = 1'b0; client_reward_valid = 4'h0;

    // Pass-through to client 2
    request = 4'b0100; client_action_ready = 4'b0100;
    tick();
    check_value("pt_grant", grant, 4'b0100);
    check_value("pt_aaready", agent_action_ready, 1'b1);
    check_value("pt_cavalid_lo", client_action_valid, 4'h0);
    agent_action_valid = 1'b1; agent_action_data = 8'h5A; request = 4'h0;
    #1;
    check_value("pt_cadata", client_action_data, 8'h5A);
    check_value("pt_cavalid", client_action_valid, 4'b0100);
    tick();
    client_reward_data = 32'h33102211; client_reward_valid = 4'b0100; agent_reward_ready = 1'b0;
    #1;
    check_value("pt_arvalid", agent_reward_valid, 1'b1);
    check_value("pt_ardata", agent_reward_data, 8'h10);
    check_value("pt_crready_bp", client_reward_ready, 4'h0);
    check_value("pt_cadata_rwd", client_action_data, 8'h00);
    agent_reward_ready = 1'b1;
    #1;
    check_value("pt_crready", client_reward_ready, 4'b0100);
    tick();
    check_value("pt_done", grant, 4'h0);

    // Timeout on client 3 (ptr=3)
    request = 4'b1000; client_action_ready = 4'hF; agent_action_valid = 1'b1;
    client_reward_valid = 4'h0; agent_reward_ready = 1'b1;
    tick();
    check_value("to_grant", grant, 4'b1000);
    tick();
    repeat (7) tick();
    check_value("to_pre_expiry", agent_reward_valid, 1'b0);
    tick();
    check_value("to_pen_valid", agent_reward_valid, 1'b1);
    check_value("to_pen_data", agent_reward_data, 8'h80);
    check_value("to_pen_crready", client_reward_ready, 4'h0);
    client_reward_data = 32'h77000042; client_reward_valid = 4'b1000;
    tick();
    check_value("to_tcount", timeout_count, 8'd1);
    check_value("to_idle", grant, 4'h0);

    // Back-pressure: single requester re-granted, agent stalls 20 cycles
    agent_reward_ready = 1'b0;
    tick();
    check_value("bp_regrant", grant, 4'b1000);
    tick();
    request = 4'h0;
    repeat (20) tick();
    check_value("bp_arvalid", agent_reward_valid, 1'b1);
    check_value("bp_ardata", agent_reward_data, 8'h77);
    agent_reward_ready = 1'b1;
    #1;
    check_value("bp_crready", client_reward_ready, 4'b1000);
    tick();
    check_value("bp_idle", grant, 4'h0);
    check_value("bp_tcount", timeout_count, 8'd1);

    // Reward arrives on the timer-expiry cycle
    request = 4'b0001; client_reward_valid = 4'h0;
    tick();
    check_value("col_grant", grant, 4'b0001);
    tick();
    request = 4'h0;
    repeat (7) tick();
    check_value("col_pre", agent_reward_valid, 1'b0);
    client_reward_valid = 4'b0001;
    #1;
    check_value("col_ardata", agent_reward_data, 8'h42);
    tick();
    check_value("col_idle_grant", grant, 4'h0);
    check_value("col_no_penalty", agent_reward_valid, 1'b0);
    check_value("col_tcount", timeout_count, 8'd1);

    // Repeated timeouts on client 1: 253 more reach 254, 46 more saturate
    request = 4'b0010; client_reward_valid = 4'h0;
    repeat (253 * 11) tick();
    check_value("sat_254", timeout_count, 8'd254);
    repeat (46 * 11) tick();
    check_value("sat_255", timeout_count, 8'd255);

    // Reset in the middle of REWARD
    tick();
    check_value("rr_pre_reset_grant", grant, 4'b0010);
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    check_value("ar_grant", grant, 4'h0);
    check_value("ar_arvalid", agent_reward_valid, 1'b0);
    check_value("ar_crready", client_reward_ready, 4'h0);
    check_value("ar_cavalid", client_action_valid, 4'h0);
    check_value("ar_tcount", timeout_count, 8'd0);
    tick();
    reset = 1'b0;
    request = 4'b0101;
    tick();
    check_value("ar_ptr_zero", grant, 4'b0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
